// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode captured into a 2-entry skid buffer.
// Optional feature macro RV_M_EXT_EN enables decoding of the M-extension OP encodings.
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int COUNT_W        = 16,
    parameter int HALT_ON_EBREAK = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_ir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [4:0]         srcreg1_num,
    output logic [4:0]         srcreg2_num,
    output logic [4:0]         dstreg_num,
    output logic [XLEN-1:0]    imm,
    output logic [5:0]         alucode,
    output logic [1:0]         aluop1_type,
    output logic [1:0]         aluop2_type,
    output logic               reg_we,
    output logic               is_load,
    output logic               is_store,
    output logic               is_halt,
    output logic               illegal,
    output logic [COUNT_W-1:0] dec_count
);

    if (XLEN != 32) begin : g_xlen_check
        $error("decode_stage supports XLEN=32 only");
    end

    localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18, ALU_XOR  = 6'd19, ALU_OR   = 6'd20;
    localparam logic [5:0] ALU_AND  = 6'd21, ALU_SLL  = 6'd22, ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24, ALU_SLT  = 6'd25, ALU_SLTU = 6'd26;
    localparam logic [5:0] ALU_MUL  = 6'd27, ALU_NOP  = 6'd63;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011, OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_SYS   = 7'b1110011;

    localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [5:0]      alucode;
        logic [1:0]      op1;
        logic [1:0]      op2;
        logic            reg_we;
        logic            is_load;
        logic            is_store;
        logic            is_halt;
        logic            illegal;
    } entry_t;

    function automatic logic [5:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = in_ir[6:0];
    assign funct3 = in_ir[14:12];
    assign funct7 = in_ir[31:25];
    assign imm_i  = {{20{in_ir[31]}}, in_ir[31:20]};
    assign imm_s  = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
    assign imm_b  = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    assign imm_u  = {in_ir[31:12], 12'b0};
    assign imm_j  = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
    assign imm_sh = {27'b0, in_ir[24:20]};

    entry_t dec;
    logic   bad, use_rs1, use_rs2, use_rd;

    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        case (opcode)
            OPC_LUI: begin
                use_rs1     = 1'b0;
                dec.imm     = imm_u;
                dec.alucode = ALU_LUI;
                dec.op1     = OP_TYPE_NONE;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                use_rs1     = 1'b0;
                dec.imm     = imm_u;
                dec.alucode = ALU_ADD;
                dec.op1     = OP_TYPE_PC;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
            end
            OPC_JAL: begin
                use_rs1     = 1'b0;
                dec.imm     = imm_j;
                dec.alucode = ALU_JAL;
                dec.op1     = OP_TYPE_PC;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
            end
            OPC_JALR: begin
                dec.imm     = imm_i;
                dec.alucode = ALU_JALR;
                dec.op1     = OP_TYPE_REG;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs2 = 1'b1;
                use_rd  = 1'b0;
                dec.imm = imm_b;
                dec.op1 = OP_TYPE_REG;
                dec.op2 = OP_TYPE_REG;
                case (funct3)
                    3'b000:  dec.alucode = ALU_BEQ;
                    3'b001:  dec.alucode = ALU_BNE;
                    3'b100:  dec.alucode = ALU_BLT;
                    3'b101:  dec.alucode = ALU_BGE;
                    3'b110:  dec.alucode = ALU_BLTU;
                    3'b111:  dec.alucode = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm     = imm_i;
                dec.op1     = OP_TYPE_REG;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
                dec.is_load = 1'b1;
                case (funct3)
                    3'b000:  dec.alucode = ALU_LB;
                    3'b001:  dec.alucode = ALU_LH;
                    3'b010:  dec.alucode = ALU_LW;
                    3'b100:  dec.alucode = ALU_LBU;
                    3'b101:  dec.alucode = ALU_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs2      = 1'b1;
                use_rd       = 1'b0;
                dec.imm      = imm_s;
                dec.op1      = OP_TYPE_REG;
                dec.op2      = OP_TYPE_REG;
                dec.is_store = 1'b1;
                case (funct3)
                    3'b000:  dec.alucode = ALU_SB;
                    3'b001:  dec.alucode = ALU_SH;
                    3'b010:  dec.alucode = ALU_SW;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.imm     = imm_i;
                dec.alucode = alu_of_f3(funct3);
                dec.op1     = OP_TYPE_REG;
                dec.op2     = OP_TYPE_IMM;
                dec.reg_we  = 1'b1;
                // shift amounts are unsigned; the upper bits select SRL/SRA instead of extending
                if (funct3 == 3'b001) begin
                    dec.imm = imm_sh;
                    bad     = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.imm = imm_sh;
                    if (funct7 == 7'b0100000) dec.alucode = ALU_SRA;
                    else if (funct7 != 7'b0000000) bad = 1'b1;
                end
            end
            OPC_OP: begin
                use_rs2    = 1'b1;
                dec.op1    = OP_TYPE_REG;
                dec.op2    = OP_TYPE_REG;
                dec.reg_we = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alucode = alu_of_f3(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alucode = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alucode = ALU_SRA;
                end else if (funct7 == 7'b0000001) begin
`ifdef RV_M_EXT_EN
                    dec.alucode = ALU_MUL + {3'b000, funct3};
`else
                    bad = 1'b1;
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_SYS: begin
                use_rs1     = 1'b0;
                use_rd      = 1'b0;
                dec.alucode = ALU_NOP;
                if (in_ir == IR_ECALL) dec.is_halt = 1'b1;
                else if (in_ir == IR_EBREAK) dec.is_halt = (HALT_ON_EBREAK != 0);
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        dec.pc  = in_pc;
        dec.rs1 = use_rs1 ? in_ir[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? in_ir[24:20] : 5'd0;
        dec.rd  = use_rd  ? in_ir[11:7]  : 5'd0;
        if (dec.rd == 5'd0) dec.reg_we = 1'b0;
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.alucode = ALU_NOP;
            dec.illegal = 1'b1;
        end
    end

    entry_t             head_q, head_d, skid_q, skid_d;
    logic               head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic [COUNT_W-1:0] dec_count_q, dec_count_d;
    logic               accept, pop;

    assign in_ready = !rst && !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = head_valid_q && out_ready;

    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        dec_count_d  = dec_count_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (accept && dec_count_q != '1)
                dec_count_d = dec_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            // accept is impossible while skid is full, so the skid-to-head move never races a push
            if (pop && skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (pop || !head_valid_q) begin
                head_valid_d = accept;
                if (accept) head_d = dec;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_d       = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            dec_count_q  <= '0;
        end else begin
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            dec_count_q  <= dec_count_d;
        end
    end

    entry_t out_e;
    assign out_e       = head_valid_q ? head_q : '0;
    assign out_valid   = head_valid_q;
    assign out_pc      = out_e.pc;
    assign srcreg1_num = out_e.rs1;
    assign srcreg2_num = out_e.rs2;
    assign dstreg_num  = out_e.rd;
    assign imm         = out_e.imm;
    assign alucode     = out_e.alucode;
    assign aluop1_type = out_e.op1;
    assign aluop2_type = out_e.op2;
    assign reg_we      = out_e.reg_we;
    assign is_load     = out_e.is_load;
    assign is_store    = out_e.is_store;
    assign is_halt     = out_e.is_halt;
    assign illegal     = out_e.illegal;
    assign dec_count   = dec_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes model predictions, negedge monitor compares head.
module tb_decode_stage;
    localparam int CW      = 4;
    localparam int HALT_EB = 1;
    localparam int CMAX    = (1 << CW) - 1;

    localparam int A_LUI = 0, A_JAL = 1, A_JALR = 2, A_ADD = 17, A_SUB = 18, A_SRA = 24;
    localparam int A_SLL = 22, A_SRL = 23, A_MUL = 27, A_NOP = 63;
    localparam logic [1:0] T_NONE = 0, T_REG = 1, T_IMM = 2, T_PC = 3;

    int alu_tab[8] = '{17, 22, 25, 26, 19, 23, 20, 21};
    int br_tab[8]  = '{3, 4, -1, -1, 5, 6, 7, 8};
    int ld_tab[8]  = '{9, 10, 11, -1, 12, 13, -1, -1};
    int st_tab[8]  = '{14, 15, 16, -1, -1, -1, -1, -1};
    logic [6:0] opc_tab[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};

    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_pc = 0, in_ir = 0;
    logic in_ready, out_valid, reg_we, is_load, is_store, is_halt, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0] srcreg1_num, srcreg2_num, dstreg_num;
    logic [5:0] alucode;
    logic [1:0] aluop1_type, aluop2_type;
    logic [CW-1:0] dec_count;

    decode_stage #(.XLEN(32), .COUNT_W(CW), .HALT_ON_EBREAK(HALT_EB)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num),
        .dstreg_num(dstreg_num), .imm(imm), .alucode(alucode), .aluop1_type(aluop1_type),
        .aluop2_type(aluop2_type), .reg_we(reg_we), .is_load(is_load), .is_store(is_store),
        .is_halt(is_halt), .illegal(illegal), .dec_count(dec_count));

    always #5 clk = ~clk;

    int total = 0, bad = 0, held = 0, exp_cnt = 0;
    logic [93:0] sb[$];
    logic [93:0] dut_vec;
    assign dut_vec = {out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm, alucode,
                      aluop1_type, aluop2_type, reg_we, is_load, is_store, is_halt, illegal};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: classify by format, then derive fields from the format rules.
    function automatic logic [93:0] model(input logic [31:0] pc, input logic [31:0] ir);
        int s = $signed(ir);
        logic [2:0] f3 = ir[14:12];
        logic [6:0] f7 = ir[31:25];
        byte fmt = "N";
        int alu = A_NOP;
        bit ok = 1, we = 0, ld = 0, st = 0, halt = 0;
        logic [1:0] t1 = T_NONE, t2 = T_NONE;
        logic [31:0] im = 0;
        logic [4:0] r1, r2, rd;
        case (ir[6:0])
            7'h37: begin fmt = "U"; alu = A_LUI; t2 = T_IMM; we = 1; end
            7'h17: begin fmt = "U"; alu = A_ADD; t1 = T_PC; t2 = T_IMM; we = 1; end
            7'h6f: begin fmt = "J"; alu = A_JAL; t1 = T_PC; t2 = T_IMM; we = 1; end
            7'h67: begin fmt = "I"; alu = A_JALR; t1 = T_REG; t2 = T_IMM; we = 1; end
            7'h63: begin fmt = "B"; alu = br_tab[f3]; t1 = T_REG; t2 = T_REG; end
            7'h03: begin fmt = "I"; alu = ld_tab[f3]; t1 = T_REG; t2 = T_IMM; we = 1; ld = 1; end
            7'h23: begin fmt = "S"; alu = st_tab[f3]; t1 = T_REG; t2 = T_REG; st = 1; end
            7'h13: begin
                t1 = T_REG; t2 = T_IMM; we = 1; fmt = "I"; alu = alu_tab[f3];
                if (f3 == 1) begin fmt = "H"; ok = (f7 == 0); end
                if (f3 == 5) begin
                    fmt = "H";
                    if (f7 == 7'h20) alu = A_SRA;
                    else if (f7 != 0) ok = 0;
                end
            end
            7'h33: begin
                fmt = "R"; t1 = T_REG; t2 = T_REG; we = 1;
                if (f7 == 0) alu = alu_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 5) alu = A_SRA;
`ifdef RV_M_EXT_EN
                else if (f7 == 7'h01) alu = A_MUL + int'(f3);
`endif
                else ok = 0;
            end
            7'h73: begin
                if (ir == 32'h73) halt = 1;
                else if (ir == 32'h00100073) halt = (HALT_EB != 0);
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (alu < 0) ok = 0;
        case (fmt)
            "I": im = s >>> 20;
            "S": im = ((s >>> 25) << 5) | int'(ir[11:7]);
            "B": im = ((s >>> 31) << 12) | (int'(ir[7]) << 11) | (int'(ir[30:25]) << 5) | (int'(ir[11:8]) << 1);
            "U": im = ir & 32'hFFFF_F000;
            "J": im = ((s >>> 31) << 20) | (int'(ir[19:12]) << 12) | (int'(ir[20]) << 11) | (int'(ir[30:21]) << 1);
            "H": im = int'(ir[24:20]);
            default: im = 0;
        endcase
        r1 = (fmt == "U" || fmt == "J" || fmt == "N") ? 5'd0 : ir[19:15];
        r2 = (fmt == "R" || fmt == "S" || fmt == "B") ? ir[24:20] : 5'd0;
        rd = (fmt == "S" || fmt == "B" || fmt == "N") ? 5'd0 : ir[11:7];
        if (!ok) return {pc, 15'd0, 32'd0, 6'(A_NOP), 4'd0, 5'b00001};
        return {pc, r1, r2, rd, im, 6'(alu), t1, t2, (we && rd != 0), ld, st, halt, 1'b0};
    endfunction

    function automatic logic [31:0] gen_ir();
        logic [31:0] r = $urandom();
        int sel = $urandom_range(0, 13);
        if (sel == 11) return 32'h0000_0073;
        if (sel == 12) return 32'h0010_0073;
        if (sel == 13) return r;
        r[6:0] = opc_tab[sel];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // One clock: drive after the edge, check handshake/counter state, then record what the edge will do.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic ordy, input logic fl, input logic r, output logic acc);
        logic exp_rdy;
        @(posedge clk);
        #2;
        in_valid = v; in_pc = pc; in_ir = ir; out_ready = ordy; flush = fl; rst = r;
        #2;
        exp_rdy = !r && held < 2;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, held > 0);
        chk("dec_count", dec_count, (exp_cnt > CMAX) ? CMAX : exp_cnt);
        acc = v && exp_rdy && !fl;
        if (r) begin
            sb.delete(); held = 0; exp_cnt = 0;
        end else if (fl) begin
            sb.delete(); held = 0;
        end else if (acc) begin
            sb.push_back(model(pc, ir)); held++; exp_cnt++;
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir, input logic ordy);
        logic acc = 0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1, pc, ir, ordy, 0, 0, acc);
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout got=not_accepted want=accepted ir=%h", ir);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0, 0, acc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid) begin
                if (sb.size() == 0) chk("out_valid_unexpected", out_valid, 0);
                else begin
                    chk("entry", dut_vec, sb[0]);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        held--;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        cycle(0, 0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);
        send(32'h0, 32'h0050_0093, 1);
        send(32'h100, 32'hFE20_8EE3, 1);
        idle(3);
        // back-pressure: two accepted, third waits, all drain in order
        send(32'h200, 32'h0010_0093, 0);
        send(32'h204, 32'h0010_0113, 0);
        cycle(1, 32'h208, 32'h0010_0193, 0, 0, 0, acc);
        send(32'h208, 32'h0010_0193, 1);
        idle(4);
        send(32'h300, 32'h0000_0000, 1);
        send(32'h304, 32'h0000_0073, 1);
        send(32'h308, 32'h0010_0073, 1);
        send(32'h30c, 32'h0220_81B3, 1);
        idle(3);
        // flush with both entries held and a new instruction offered
        send(32'h400, 32'h0010_0093, 0);
        send(32'h404, 32'h0010_0113, 0);
        cycle(1, 32'h408, 32'h0010_0193, 0, 1, 0, acc);
        idle(2);
        // reset mid-stream
        send(32'h500, 32'h0010_0093, 0);
        send(32'h504, 32'h0010_0113, 0);
        cycle(1, 32'h508, 32'h0010_0193, 0, 0, 1, acc);
        idle(2);
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom() & 32'hFFFF_FFFC, gen_ir(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 149) == 0, acc);
        end
        for (int i = 0; i < 30 && sb.size() > 0; i++) cycle(0, 0, 0, 1, 0, 0, acc);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d want=0 entries left", sb.size());
        end
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
